// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: load funct3 codes, FSM states
// and the load-extension helper.
package shrv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Selects the byte/half at byte offset off and extends it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  off);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (funct3)
      F3_LB:   return {{24{sh[7]}}, sh[7:0]};
      F3_LH:   return {{16{sh[15]}}, sh[15:0]};
      F3_LW:   return sh;
      F3_LBU:  return {24'h000000, sh[7:0]};
      F3_LHU:  return {16'h0000, sh[15:0]};
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channel between the core pipeline (master)
// and the data-memory responder (slave).
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_byteena;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_byteena, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_byteena, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_ram.sv
// Single-port 2**ADDR_W x 32 RAM with per-byte write enables and a registered read port.
module dmem_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [3:0]        we_i,
  input  logic [31:0]       wdata_i,
  input  logic              re_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  // Read data only changes on a read, so it stays valid for the whole wait period.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time and answers after wait states.
// Define MISALIGN_TRAP_EN to report misaligned accesses on rsp_err instead of forcing alignment.
module dmem_responder
  import shrv_mem_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_responder_if.slave bus
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        mis_q;

  logic              accept;
  logic              is_word, is_half, mis;
  logic [1:0]        off_raw, off_eff;
  logic [3:0]        lanes, ram_we;
  logic [31:0]       wdata_sh, ram_rdata;
  logic              ram_re;
  logic [ADDR_W-1:0] idx;
  logic              unused_addr_hi;

  assign accept         = bus.req_valid && bus.req_ready;
  assign off_raw        = bus.req_addr[1:0];
  assign idx            = bus.req_addr[ADDR_W+1:2];
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

  // Stores size themselves by lane mask, loads by funct3.
  always_comb begin
    is_word = 1'b0;
    is_half = 1'b0;
    if (bus.req_we) begin
      is_word = (bus.req_byteena == 4'b1111);
      is_half = (bus.req_byteena == 4'b0011);
    end else begin
      is_word = (bus.req_funct3[1:0] == 2'b10);
      is_half = (bus.req_funct3[1:0] == 2'b01);
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign mis     = (is_half && off_raw[0]) || (is_word && (off_raw != 2'b00));
  assign off_eff = off_raw;
`else
  assign mis     = 1'b0;
  assign off_eff = is_word ? 2'b00 : (is_half ? {off_raw[1], 1'b0} : off_raw);
`endif

  assign lanes    = bus.req_byteena << off_eff;
  assign wdata_sh = bus.req_wdata << {off_eff, 3'b000};
  assign ram_we   = (accept && bus.req_we && !mis) ? lanes : 4'b0000;
  assign ram_re   = accept && !bus.req_we && !mis;

  dmem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .addr_i  (idx),
    .we_i    (ram_we),
    .wdata_i (wdata_sh),
    .re_i    (ram_re),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q     <= bus.req_we;
      funct3_q <= bus.req_funct3;
      off_q    <= off_eff;
      mis_q    <= mis;
    end
  end

  // WAIT always holds one cycle for the registered RAM read; WAIT_CYCLES adds to that.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = WAIT_CNT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          rdata_d = (we_q || mis_q) ? 32'h0000_0000 : load_extend(ram_rdata, funct3_q, off_q);
          err_d   = mis_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = rst_n && (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed load/store scenarios plus randomized traffic,
// checked every cycle against a byte-level memory model.
module tb_dmem_responder;

  localparam int AW = 12;
  localparam int W  = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(
    .ADDR_W      (AW),
    .WAIT_CYCLES (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        wr;
    logic [31:0] word;
    logic [31:0] rdata;
    logic        err;
  } acc_t;

  logic [31:0] mem [0:(1<<AW)-1];
  int          ecnt     = 0;
  int          due      = 0;
  int          acc_cnt  = 0;
  int          last_acc = 0;
  bit          pending  = 1'b0;
  bit          was_rst  = 1'b0;
  bit          chk_en   = 1'b0;
  logic [31:0] exp_rdata = 32'h0;
  logic        exp_err   = 1'b0;
  acc_t        res_now;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h, want %h (edge %0d)", nm, act, want, ecnt);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out (edge %0d)", nm, ecnt);
  endtask

  function automatic logic [31:0] load_val(input logic [31:0] word, input int o,
                                           input logic [2:0] f3);
    logic [31:0] sh;
    sh = word >> (8 * o);
    case (f3)
      3'd0:    return 32'($signed(sh[7:0]));
      3'd1:    return 32'($signed(sh[15:0]));
      3'd2:    return sh;
      3'd4:    return {24'd0, sh[7:0]};
      3'd5:    return {16'd0, sh[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  // What one accepted access must do: new word contents and the response it earns.
  function automatic acc_t model_access(input logic [31:0] word, input logic we,
                                        input logic [31:0] addr, input logic [31:0] wdata,
                                        input logic [3:0] be, input logic [2:0] f3);
    acc_t r;
    int   sz;
    int   o;
    r.wr    = 1'b0;
    r.word  = word;
    r.rdata = 32'd0;
    r.err   = 1'b0;
    if (we) sz = (be == 4'hF) ? 4 : ((be == 4'h3) ? 2 : 1);
    else    sz = (f3[1:0] == 2'b10) ? 4 : ((f3[1:0] == 2'b01) ? 2 : 1);
    o = int'(addr[1:0]);
`ifdef MISALIGN_TRAP_EN
    if ((o % sz) != 0) begin
      r.err = 1'b1;
      return r;
    end
`else
    o = o - (o % sz);
`endif
    if (we) begin
      r.wr = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (be[k] && (k + o) < 4) r.word[8*(k+o) +: 8] = wdata[8*k +: 8];
      end
    end else begin
      r.rdata = load_val(word, o, f3);
    end
    return r;
  endfunction

  assign res_now = model_access(mem[bus.req_addr[AW+1:2]], bus.req_we, bus.req_addr,
                                bus.req_wdata, bus.req_byteena, bus.req_funct3);

  // Model: one transaction in flight, response visible 1+W edges after accept.
  always @(posedge clk) begin
    ecnt    <= ecnt + 1;
    was_rst <= !rst_n;
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (pending) begin
      if ((ecnt + 1) > due && bus.rsp_ready) pending <= 1'b0;
    end else if (bus.req_valid) begin
      if (res_now.wr) mem[bus.req_addr[AW+1:2]] <= res_now.word;
      exp_rdata <= res_now.rdata;
      exp_err   <= res_now.err;
      pending   <= 1'b1;
      due       <= ecnt + 2 + W;
      acc_cnt   <= acc_cnt + 1;
      last_acc  <= ecnt + 1;
    end
  end

  // Compare: every cycle once the first reset edge has passed.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(pending && ecnt >= due));
      chk("req_ready", 32'(bus.req_ready), 32'(rst_n && !pending));
      if (pending && ecnt >= due) begin
        chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
        chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
      end
      if (was_rst) begin
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_err", 32'(bus.rsp_err), 32'd0);
      end
    end
  end

  task automatic scramble();
    bus.req_we      = 1'($urandom);
    bus.req_addr    = $urandom;
    bus.req_wdata   = $urandom;
    bus.req_byteena = 4'($urandom);
    bus.req_funct3  = 3'($urandom);
  endtask

  // Called and returns at posedge+1.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input logic [2:0] f3, input int hold,
                     output logic [31:0] rd, output logic er);
    int acc0;
    int t;
    rd = 32'd0;
    er = 1'b0;
    acc0 = acc_cnt;
    bus.req_valid   = 1'b1;
    bus.req_we      = we;
    bus.req_addr    = addr;
    bus.req_wdata   = wdata;
    bus.req_byteena = be;
    bus.req_funct3  = f3;
    bus.rsp_ready   = 1'b0;
    t = 0;
    while (acc_cnt == acc0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    bus.req_valid = 1'b0;
    scramble();
    if (acc_cnt == acc0) begin
      fail("accept");
      return;
    end
    t = 0;
    while (bus.rsp_valid !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (bus.rsp_valid !== 1'b1) begin
      fail("response");
    end else begin
      chk("latency", 32'(ecnt - last_acc), 32'(1 + W));
      rd = bus.rsp_rdata;
      er = bus.rsp_err;
    end
    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  logic [31:0] t5_word;
  logic        t5_err;

  initial begin
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    scramble();
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;

    // Word store then load.
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd2, 0, rd, er);
    chk("t1_sw_rdata", rd, 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 3'd2, 0, rd, er);
    chk("t1_lw", rd, 32'hDEADBEEF);
    chk("t1_model", exp_rdata, 32'hDEADBEEF);

    // Byte store into the top lane, then signed/unsigned/half loads.
    txn(1'b1, 32'h13, 32'h80, 4'h1, 3'd0, 0, rd, er);
    txn(1'b0, 32'h13, 32'h0, 4'h0, 3'd0, 0, rd, er);
    chk("t2_lb", rd, 32'hFFFFFF80);
    chk("t2_lb_model", exp_rdata, 32'hFFFFFF80);
    txn(1'b0, 32'h13, 32'h0, 4'h0, 3'd4, 0, rd, er);
    chk("t2_lbu", rd, 32'h00000080);
    txn(1'b0, 32'h12, 32'h0, 4'h0, 3'd1, 0, rd, er);
    chk("t2_lh", rd, 32'hFFFF80AD);
    chk("t2_lh_model", exp_rdata, 32'hFFFF80AD);

    // Consumer stalls for 5 cycles.
    txn(1'b0, 32'h10, 32'h0, 4'h0, 3'd2, 5, rd, er);
    chk("t3_lw_held", rd, 32'h80ADBEEF);
    @(negedge clk);
    chk("t3_idle_ready", 32'(bus.req_ready), 32'd1);
    chk("t3_idle_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;

    // Address wrap above the RAM size.
    txn(1'b0, 32'h10 + (32'd4 << AW), 32'h0, 4'h0, 3'd2, 0, rd, er);
    chk("t4_wrap_lw", rd, 32'h80ADBEEF);
    txn(1'b1, 32'hFFFF4010, 32'h12345678, 4'hF, 3'd2, 0, rd, er);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 3'd2, 0, rd, er);
    chk("t4_wrap_sw", rd, 32'h12345678);

    // Misaligned word store.
`ifdef MISALIGN_TRAP_EN
    t5_word = 32'h12345678;
    t5_err  = 1'b1;
`else
    t5_word = 32'hCAFEF00D;
    t5_err  = 1'b0;
`endif
    txn(1'b1, 32'h11, 32'hCAFEF00D, 4'hF, 3'd2, 0, rd, er);
    chk("t5_sw_err", 32'(er), 32'(t5_err));
    txn(1'b0, 32'h10, 32'h0, 4'h0, 3'd2, 0, rd, er);
    chk("t5_word", rd, t5_word);

    // Reset while a load is waiting.
    begin
      int acc0;
      int t;
      acc0 = acc_cnt;
      bus.req_valid   = 1'b1;
      bus.req_we      = 1'b0;
      bus.req_addr    = 32'h10;
      bus.req_funct3  = 3'd2;
      bus.req_byteena = 4'h0;
      t = 0;
      while (acc_cnt == acc0 && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      if (acc_cnt == acc0) fail("t6_accept");
      bus.req_valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) begin
        @(posedge clk); #1;
      end
      rst_n = 1'b1;
      repeat (3) begin
        @(negedge clk);
        chk("t6_no_rsp", 32'(bus.rsp_valid), 32'd0);
      end
      @(posedge clk); #1;
    end
    txn(1'b0, 32'h10, 32'h0, 4'h0, 3'd2, 0, rd, er);
    chk("t6_store_kept", rd, t5_word);

    // Known contents for the randomized window (words 0..31).
    for (int i = 0; i < 32; i++) begin
      txn(1'b1, 32'(i * 4), $urandom, 4'hF, 3'd2, 0, rd, er);
    end

    // Random traffic: valid/ready toggle freely, fields change every cycle.
    for (int i = 0; i < 1500; i++) begin
      bus.req_valid   = ($urandom % 3) != 0;
      bus.req_we      = 1'($urandom);
      bus.req_addr    = $urandom & 32'hFFFF_C07F;
      bus.req_wdata   = $urandom;
      case ($urandom % 4)
        0:       bus.req_byteena = 4'h1;
        1:       bus.req_byteena = 4'h3;
        2:       bus.req_byteena = 4'hF;
        default: bus.req_byteena = 4'($urandom);
      endcase
      bus.req_funct3  = 3'($urandom);
      bus.rsp_ready   = ($urandom % 3) != 0;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
